// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_pkg;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // RISC-V load/store width codes (funct3).
    localparam logic [2:0] F3Byte  = 3'd0;
    localparam logic [2:0] F3Half  = 3'd1;
    localparam logic [2:0] F3Word  = 3'd2;
    localparam logic [2:0] F3ByteU = 3'd4;
    localparam logic [2:0] F3HalfU = 3'd5;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        ack;
    logic        fault;
    logic        busy;

    modport master (
        output req, we, funct3, addr, wrdata,
        input  rddata, ack, fault, busy
    );

    modport slave (
        input  req, we, funct3, addr, wrdata,
        output rddata, ack, fault, busy
    );
endinterface

// File: rtl/bram_bytewe.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read.
// No reset: contents and read register survive reset.
module bram_bytewe #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-masked write and read-before-write registered read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Load/store responder: accepts one request, accesses RAM, then pulses ack
// with the extended load data or a fault.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] Limit = {1'b0, BASE} + 33'(DEPTH_WORDS) * 33'd4;

    state_e      r_state;
    state_e      w_state_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wrdata;

    // Response-side copies so rddata/fault stay put after a new request is latched.
    logic        r_fault;
    logic        r_rd_valid;
    logic [2:0]  r_rd_funct3;
    logic [1:0]  r_rd_lane;

    logic [31:0] w_offset;
    logic [AW-1:0] w_index;
    logic        w_out_of_range;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_fault;
    logic        w_ram_en;
    logic [3:0]  w_ram_be;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rddata;
    logic        w_unused;

    assign w_offset       = r_addr - BASE;
    assign w_index        = w_offset[AW+1:2];
    assign w_unused       = ^{w_offset[31:AW+2], w_offset[1:0]};
    assign w_out_of_range = (r_addr < BASE) || ({1'b0, r_addr} >= Limit);
    assign w_fault        = w_out_of_range || w_misaligned || w_illegal;
    assign w_ram_en       = (r_state == StAccess) && !w_fault;

    // State register; async reset aborts any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: only IDLE waits on req, the other two states are single cycles.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (bus.req) w_state_next = StAccess;
            StAccess: w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wrdata <= 32'd0;
        end else if (r_state == StIdle && bus.req) begin
            r_we     <= bus.we;
            r_funct3 <= bus.funct3;
            r_addr   <= bus.addr;
            r_wrdata <= bus.wrdata;
        end
    end

    // Width legality and alignment of the latched request.
    always_comb begin
        w_misaligned = 1'b0;
        w_illegal    = 1'b0;
        if (r_we) begin
            case (r_funct3)
                F3Byte:  w_misaligned = 1'b0;
                F3Half:  w_misaligned = r_addr[0];
                F3Word:  w_misaligned = |r_addr[1:0];
                default: w_illegal    = 1'b1;
            endcase
        end else begin
            case (r_funct3)
                F3Byte, F3ByteU: w_misaligned = 1'b0;
                F3Half, F3HalfU: w_misaligned = r_addr[0];
                F3Word:          w_misaligned = |r_addr[1:0];
                default:         w_illegal    = 1'b1;
            endcase
        end
    end

    // Store lane steering: replicate data so every enabled lane sees its bytes.
    always_comb begin
        w_ram_be    = 4'b0000;
        w_ram_wdata = r_wrdata;
        if (r_we) begin
            case (r_funct3)
                F3Byte: begin
                    w_ram_be    = 4'b0001 << r_addr[1:0];
                    w_ram_wdata = {4{r_wrdata[7:0]}};
                end
                F3Half: begin
                    w_ram_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                    w_ram_wdata = {2{r_wrdata[15:0]}};
                end
                F3Word:  w_ram_be = 4'b1111;
                default: w_ram_be = 4'b0000;
            endcase
        end
    end

    bram_bytewe #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_be    (w_ram_be),
        .i_addr  (w_index),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Result status is registered as ACCESS ends, alongside the RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_funct3 <= 3'd0;
            r_rd_lane   <= 2'd0;
        end else if (r_state == StAccess) begin
            r_fault     <= w_fault;
            r_rd_valid  <= !r_we && !w_fault;
            r_rd_funct3 <= r_funct3;
            r_rd_lane   <= r_addr[1:0];
        end
    end

    // Load lane selection and sign/zero extension; zero unless a good load.
    always_comb begin
        unique case (r_rd_lane)
            2'd0:    w_byte = w_ram_rdata[7:0];
            2'd1:    w_byte = w_ram_rdata[15:8];
            2'd2:    w_byte = w_ram_rdata[23:16];
            default: w_byte = w_ram_rdata[31:24];
        endcase
        w_half   = r_rd_lane[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];
        w_rddata = 32'd0;
        if (r_rd_valid) begin
            case (r_rd_funct3)
                F3Byte:  w_rddata = {{24{w_byte[7]}}, w_byte};
                F3ByteU: w_rddata = {24'd0, w_byte};
                F3Half:  w_rddata = {{16{w_half[15]}}, w_half};
                F3HalfU: w_rddata = {16'd0, w_half};
                default: w_rddata = w_ram_rdata;
            endcase
        end
    end

    assign bus.rddata = w_rddata;
    assign bus.fault  = r_fault;
    assign bus.ack    = (r_state == StResp);
    assign bus.busy   = (r_state != StIdle);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning the byte address of RAM word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  request valid; sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  RISC-V load/store width code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wrdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rddata  output  32  load result, extended to 32 bits.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port fault  output  1  valid with ack; 1 = access rejected.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RESP; IDLE->ACCESS on req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 SHALL latch we, funct3, addr and wrdata on the IDLE cycle that req=1; inputs in other states are ignored.
REQ-016 SHALL perform the RAM read or write in ACCESS and assert ack for exactly the RESP cycle, giving latency 2 cycles from acceptance; throughput is one request per 3 cycles with req held high.
REQ-017 SHALL compute the word index as (addr-BASE)>>2 and the byte lane as addr[1:0], little-endian.
REQ-018 SHALL raise fault when addr<BASE or addr>=BASE+4*DEPTH_WORDS (out of range).
REQ-019 SHALL raise fault for misalignment: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-020 SHALL raise fault for illegal funct3: loads 3, 6, 7; stores greater than 2.
REQ-021 SHALL suppress any RAM write on a faulting request and drive rddata=0 with ack=1, fault=1.
REQ-022 SHALL write SB to the byte lane addr[1:0] from wrdata[7:0], SH to lanes {addr[1],0} and {addr[1],1} from wrdata[15:0], and SW to all four lanes; other lanes are unchanged.
REQ-023 SHALL sign-extend LB/LH and zero-extend LBU/LHU from the selected lane(s); LW returns the full word.
REQ-024 SHALL drive rddata=0 for stores.
REQ-025 SHALL hold rddata and fault stable from RESP until the next RESP.
REQ-026 SHALL hold ack low in all states other than RESP.

Reset
REQ-027 SHALL on reset force state=IDLE, ack=0, fault=0, rddata=0, busy=0 and clear the latched request, including reset asserted mid-ACCESS or mid-RESP.
REQ-028 SHALL NOT clear RAM contents on reset.
REQ-029 SHALL NOT complete a write to RAM when reset is asserted during ACCESS.

Structure
REQ-030 SHALL place the state encoding and the funct3 width constants in shared package mem_pkg.
REQ-031 SHALL instantiate one sub-module, bram_bytewe: a synchronous single-port RAM with 4-bit byte-enable, registered read and no reset.
REQ-032 SHALL contain the alignment/fault check, the lane steering and the extension logic in mem_responder itself.

Verification
REQ-033 SHALL cover: SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> ack 2 cycles after acceptance, rddata=0xDEADBEEF, fault=0.
REQ-034 SHALL cover: SB addr=0x13 data=0x80 over 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-035 SHALL cover: SH addr=0x11 -> ack with fault=1; LW 0x10 unchanged; LW 0x12 -> fault=1; LH 0x12 -> fault=0.
REQ-036 SHALL cover: LW addr=BASE+4*DEPTH_WORDS -> fault=1, rddata=0; funct3=3 load -> fault=1.
REQ-037 SHALL cover: req held high for 9 cycles -> exactly 3 acks, one every 3 cycles; busy low only in the IDLE cycles.
REQ-038 SHALL cover: SW 0x20 data=0x12345678 with reset asserted in the ACCESS cycle -> no ack, outputs 0; a subsequent LW 0x20 returns the prior contents.
